gol_bank_ctrl: RTL and testbench

Parametrised N-buffer frame-store controller for the Game of Life datapath. It replaces the fixed two-bank ping-pong select and per-frame generation gating in the top level. It owns per-bank lifecycle state, grants write banks to the engine through a req/grant/done handshake, swaps the display bank only at video start-of-frame (tear-free), and divides video frames into generation ticks at a runtime speed. It also muxes bank read data to the display and engine ports and generates per-bank write enables. With NUM_BANKS>=3 the engine runs ahead of the display (triple buffering); NUM_BANKS=2 reproduces classic ping-pong.

---
 rtl/gol_pkg.sv | 14 +
 rtl/gol_gen_divider.sv | 25 ++
 rtl/gol_bank_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_gol_bank_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life frame-store datapath.
package gol_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WRITE = 2'd1,
    READY = 2'd2,
    SHOW  = 2'd3
  } bank_state_t;

  localparam int GEN_CNT_W  = 16;
  localparam int DEF_DATA_W = 5;

endpackage

// File: rtl/gol_gen_divider.sv
// Generation-rate divider: one tick every speed+1 video frames.
module gol_gen_divider #(
  parameter int SPEED_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               video_sof,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  logic [SPEED_W-1:0] count;

  // Compare with >= so lowering speed mid-count ticks on the very next frame.
  assign tick = video_sof && (count >= speed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (video_sof) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/gol_bank_ctrl.sv
// N-buffer frame-store controller: bank lifecycle, engine grant handshake, tear-free display swap.
// Optional statistics counters (drop_ticks, skip_gens) are built when GOL_BANK_STATS_EN is defined.
module gol_bank_ctrl
  import gol_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int SPEED_W   = 4,
  localparam int BW        = (NUM_BANKS <= 2) ? 1 : $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        video_sof,
  input  logic [SPEED_W-1:0]          speed,
  input  logic                        eng_req,
  output logic                        eng_grant,
  input  logic                        eng_done,
  input  logic                        eng_init,
  input  logic                        eng_we,
  output logic [BW-1:0]               eng_rd_bank,
  output logic [BW-1:0]               eng_wr_bank,
  output logic [NUM_BANKS-1:0]        bank_we,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_dout_a,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_dout_b,
  output logic [DATA_W-1:0]           dout_display,
  output logic [DATA_W-1:0]           dout_engine,
  output logic [BW-1:0]               disp_bank,
  output logic [GEN_CNT_W-1:0]        gen_count,
  output logic [GEN_CNT_W-1:0]        drop_ticks,
  output logic [GEN_CNT_W-1:0]        skip_gens
);

  bank_state_t state_q [NUM_BANKS];
  bank_state_t state_d [NUM_BANKS];

  logic          tick;
  logic          tick_pending;
  logic [BW-1:0] newest_idx;
  logic          has_ready, has_write, free_ok;
  logic [BW-1:0] ready_idx, write_idx, free_idx;
  logic          grant_fire, done_fire, swap_fire;
  logic [BW-1:0] disp_bank_p1, eng_rd_bank_p1;

  gol_gen_divider #(
    .SPEED_W (SPEED_W)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .video_sof (video_sof),
    .speed     (speed),
    .tick      (tick)
  );

  // Descending scan so the lowest-index FREE bank wins.
  always_comb begin
    has_ready = 1'b0;
    has_write = 1'b0;
    free_ok   = 1'b0;
    ready_idx = '0;
    write_idx = '0;
    free_idx  = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        free_ok  = 1'b1;
        free_idx = BW'(i);
      end
      if (state_q[i] == READY) begin
        has_ready = 1'b1;
        ready_idx = BW'(i);
      end
      if (state_q[i] == WRITE) begin
        has_write = 1'b1;
        write_idx = BW'(i);
      end
    end
  end

  assign grant_fire = eng_req && tick_pending && !has_write && free_ok && !eng_init;
  assign done_fire  = eng_done && has_write;
  assign swap_fire  = video_sof && has_ready;

  // A simultaneous swap consumes the pre-cycle READY bank, so the completing one is not a skip.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      state_d[i] = state_q[i];
      if (swap_fire && (BW'(i) == ready_idx)) begin
        state_d[i] = SHOW;
      end else if (swap_fire && (state_q[i] == SHOW)) begin
        state_d[i] = FREE;
      end else if (done_fire && (state_q[i] == WRITE)) begin
        state_d[i] = READY;
      end else if (done_fire && (state_q[i] == READY)) begin
        state_d[i] = FREE;
      end else if (grant_fire && (BW'(i) == free_idx)) begin
        state_d[i] = WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= (i == 0) ? SHOW : FREE;
      end
      disp_bank    <= '0;
      newest_idx   <= '0;
      eng_rd_bank  <= '0;
      eng_wr_bank  <= '0;
      eng_grant    <= 1'b0;
      tick_pending <= 1'b0;
      gen_count    <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= state_d[i];
      end
      eng_grant    <= grant_fire;
      tick_pending <= tick || (tick_pending && !grant_fire);
      if (swap_fire) begin
        disp_bank <= ready_idx;
      end
      if (grant_fire) begin
        eng_wr_bank <= free_idx;
        eng_rd_bank <= newest_idx;
      end
      if (done_fire) begin
        newest_idx <= write_idx;
        gen_count  <= gen_count + 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: bank selects aligned to the 1-cycle RAM read latency ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bank_p1   <= '0;
      eng_rd_bank_p1 <= '0;
    end else begin
      disp_bank_p1   <= disp_bank;
      eng_rd_bank_p1 <= eng_rd_bank;
    end
  end

  always_comb begin
    dout_display = '0;
    dout_engine  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (disp_bank_p1 == BW'(i)) begin
        dout_display = bank_dout_a[i*DATA_W +: DATA_W];
      end
      if (eng_rd_bank_p1 == BW'(i)) begin
        dout_engine = bank_dout_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_we[i] = eng_we && (eng_init ||
                   ((eng_wr_bank == BW'(i)) && (state_q[i] == WRITE)));
    end
  end

`ifdef GOL_BANK_STATS_EN
  function automatic logic [GEN_CNT_W-1:0] sat_inc(input logic [GEN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [GEN_CNT_W-1:0] drop_cnt, skip_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      if (tick && tick_pending && !grant_fire) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      if (done_fire && has_ready && !swap_fire) begin
        skip_cnt <= sat_inc(skip_cnt);
      end
    end
  end

  assign drop_ticks = drop_cnt;
  assign skip_gens  = skip_cnt;
`else
  assign drop_ticks = '0;
  assign skip_gens  = '0;
`endif

endmodule

// File: tb/tb_gol_bank_ctrl.sv
// Randomised bench for gol_bank_ctrl (3 banks) against a set-based behavioural model.
module tb_gol_bank_ctrl;

  localparam int NB = 3;
  localparam int DW = 5;
`ifdef GOL_BANK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             video_sof = 1'b0;
  logic [3:0]       speed = 4'd2;
  logic             eng_req = 1'b0;
  logic             eng_done = 1'b0;
  logic             eng_init = 1'b0;
  logic             eng_we = 1'b0;
  logic [NB*DW-1:0] bank_dout_a = '0;
  logic [NB*DW-1:0] bank_dout_b = '0;
  logic             eng_grant;
  logic [1:0]       eng_rd_bank, eng_wr_bank, disp_bank;
  logic [NB-1:0]    bank_we;
  logic [DW-1:0]    dout_display, dout_engine;
  logic [15:0]      gen_count, drop_ticks, skip_gens;

  gol_bank_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .SPEED_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .video_sof    (video_sof),
    .speed        (speed),
    .eng_req      (eng_req),
    .eng_grant    (eng_grant),
    .eng_done     (eng_done),
    .eng_init     (eng_init),
    .eng_we       (eng_we),
    .eng_rd_bank  (eng_rd_bank),
    .eng_wr_bank  (eng_wr_bank),
    .bank_we      (bank_we),
    .bank_dout_a  (bank_dout_a),
    .bank_dout_b  (bank_dout_b),
    .dout_display (dout_display),
    .dout_engine  (dout_engine),
    .disp_bank    (disp_bank),
    .gen_count    (gen_count),
    .drop_ticks   (drop_ticks),
    .skip_gens    (skip_gens)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which bank is shown, which (if any) is ready, which (if any) is being written.
  int m_show, m_ready, m_write, m_newest, m_rd, m_wr, m_gen, m_div, m_drop, m_skip, m_dd, m_rdd;
  bit m_grant, m_pend;
  int t_free;
  bit t_tick, t_gr, t_dn, t_sw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_show = 0; m_ready = -1; m_write = -1; m_newest = 0;
      m_rd = 0; m_wr = 0; m_gen = 0; m_div = 0; m_drop = 0; m_skip = 0;
      m_dd = 0; m_rdd = 0; m_grant = 1'b0; m_pend = 1'b0;
    end else begin
      t_tick = video_sof && (m_div >= int'(speed));
      if (video_sof) m_div = t_tick ? 0 : m_div + 1;
      t_free = -1;
      for (int b = NB - 1; b >= 0; b--)
        if (b != m_show && b != m_ready && b != m_write) t_free = b;
      t_gr = eng_req && m_pend && (m_write < 0) && (t_free >= 0) && !eng_init;
      t_dn = eng_done && (m_write >= 0);
      t_sw = video_sof && (m_ready >= 0);
      m_dd = m_show;
      m_rdd = m_rd;
      if (t_gr) begin
        m_wr = t_free;
        m_rd = m_newest;
      end
      if (t_sw) begin
        m_show = m_ready;
        m_ready = -1;
      end
      if (t_dn) begin
        if (m_ready >= 0 && m_skip < 65535) m_skip++;
        m_ready = m_write;
        m_newest = m_write;
        m_write = -1;
        m_gen = (m_gen + 1) % 65536;
      end
      if (t_gr) m_write = t_free;
      if (t_tick && m_pend && !t_gr && m_drop < 65535) m_drop++;
      m_pend = t_tick ? 1'b1 : (t_gr ? 1'b0 : m_pend);
      m_grant = t_gr;
    end
  end

  logic [NB-1:0] t_we;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int b = 0; b < NB; b++) t_we[b] = eng_we && (eng_init || b == m_write);
      chk("disp_bank", 32'(disp_bank), m_show);
      chk("eng_rd_bank", 32'(eng_rd_bank), m_rd);
      chk("eng_wr_bank", 32'(eng_wr_bank), m_wr);
      chk("eng_grant", 32'(eng_grant), 32'(m_grant));
      chk("gen_count", 32'(gen_count), m_gen);
      chk("bank_we", 32'(bank_we), 32'(t_we));
      chk("dout_display", 32'(dout_display), 32'(bank_dout_a[m_dd*DW +: DW]));
      chk("dout_engine", 32'(dout_engine), 32'(bank_dout_b[m_rdd*DW +: DW]));
      chk("drop_ticks", 32'(drop_ticks), STATS ? m_drop : 0);
      chk("skip_gens", 32'(skip_gens), STATS ? m_skip : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bank_dout_a = 15'($urandom);
    bank_dout_b = 15'($urandom);
  endtask

  task automatic pulse_sof();
    video_sof = 1'b1;
    step();
    video_sof = 1'b0;
  endtask

  bit got;
  int cd, gw, gr;

  initial begin
    repeat (3) step();
    chk("rst_disp", 32'(disp_bank), 0);
    chk("rst_grant", 32'(eng_grant), 0);
    chk("rst_gen", 32'(gen_count), 0);
    chk("rst_bank_we", 32'(bank_we), 0);
    eng_init = 1'b1; eng_we = 1'b1; #1;
    chk("init_we_all", 32'(bank_we), 32'b111);
    eng_init = 1'b0; #1;
    chk("we_no_write", 32'(bank_we), 0);
    eng_we = 1'b0;
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // speed=2: ticks on sof 3, 6, 9; engine completes 10 cycles after each grant
    eng_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      pulse_sof();
      got = 1'b0; cd = 0; gw = 0; gr = 0;
      for (int c = 0; c < 15; c++) begin
        eng_done = (cd == 1);
        if (cd > 0) cd--;
        step();
        if (eng_grant) begin
          got = 1'b1; gw = 32'(eng_wr_bank); gr = 32'(eng_rd_bank); cd = 10;
        end
      end
      eng_done = 1'b0;
      chk("grant_after_sof", 32'(got), 32'(k % 3 == 0));
      if (k == 3) begin chk("g3_wr", gw, 1); chk("g3_rd", gr, 0); end
      if (k == 4) chk("disp_after_sof4", 32'(disp_bank), 1);
      if (k == 6) begin chk("g6_wr", gw, 0); chk("g6_rd", gr, 1); end
      if (k == 7) chk("disp_after_sof7", 32'(disp_bank), 0);
      if (k == 9) begin chk("g9_wr", gw, 1); chk("g9_rd", gr, 0); end
    end
    chk("gen_after_9", 32'(gen_count), 3);

    // speed=0: set up a READY bank and a WRITE bank, then collide sof with done
    speed = 4'd0;
    pulse_sof();
    step();
    chk("b1_grant", 32'(eng_grant), 1);
    chk("b1_wr", 32'(eng_wr_bank), 0);
    chk("b1_disp", 32'(disp_bank), 1);
    step();
    pulse_sof();
    step();
    eng_done = 1'b1; step(); eng_done = 1'b0;
    step();
    chk("b3_wr", 32'(eng_wr_bank), 2);
    chk("b3_rd", 32'(eng_rd_bank), 0);
    video_sof = 1'b1; eng_done = 1'b1; step(); video_sof = 1'b0; eng_done = 1'b0;
    chk("coll_disp", 32'(disp_bank), 0);
    chk("coll_skip", 32'(skip_gens), 0);
    chk("coll_gen", 32'(gen_count), 5);
    step();
    chk("b4_wr", 32'(eng_wr_bank), 1);
    chk("b4_rd", 32'(eng_rd_bank), 2);
    eng_done = 1'b1; step(); eng_done = 1'b0;
    chk("skip_one", 32'(skip_gens), STATS ? 1 : 0);
    pulse_sof();
    chk("show_newest", 32'(disp_bank), 1);
    step();
    eng_we = 1'b1; #1;
    chk("we_write_bank", 32'(bank_we), 32'b001);

    // asynchronous reset in the middle of a generation
    #2 rst_n = 1'b0; #1;
    chk("arst_disp", 32'(disp_bank), 0);
    chk("arst_we", 32'(bank_we), 0);
    chk("arst_grant", 32'(eng_grant), 0);
    chk("arst_gen", 32'(gen_count), 0);
    chk("arst_wr", 32'(eng_wr_bank), 0);
    chk("arst_rd", 32'(eng_rd_bank), 0);
    eng_we = 1'b0;
    step(); step();
    rst_n = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) speed = 4'($urandom_range(0, 3));
      video_sof = ($urandom % 6) == 0;
      eng_req   = ($urandom % 4) != 0;
      eng_done  = ($urandom % 5) == 0;
      eng_init  = ($urandom % 40) == 0;
      eng_we    = 1'($urandom);
      step();
    end
    video_sof = 1'b0; eng_done = 1'b0; eng_req = 1'b0; eng_init = 1'b0; eng_we = 1'b0;
    step(); step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
